// File: rtl/systolic_result_tx_if.sv
// systolic_result_tx_if: control, accumulator-row and output-row bundle for systolic_result_tx
// Ports: start/frame_rows/shift_amt in; busy/done/cfg_err out;
//        acc_data/acc_valid in, acc_ready out; data_out_data/valid/eop out, data_out_ready in.
// The master modport drives the block; slave is the block's own view.
interface systolic_result_tx_if #(
  parameter int LANES = 32,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
);
  logic                   start;
  logic [5:0]             frame_rows;
  logic [4:0]             shift_amt;
  logic                   busy;
  logic                   done;
  logic                   cfg_err;
  logic [LANES*ACC_W-1:0] acc_data;
  logic                   acc_valid;
  logic                   acc_ready;
  logic [LANES*OUT_W-1:0] data_out_data;
  logic                   data_out_valid;
  logic                   data_out_ready;
  logic                   data_out_eop;
  modport master (
    output start, frame_rows, shift_amt, acc_data, acc_valid, data_out_ready,
    input  busy, done, cfg_err, acc_ready, data_out_data, data_out_valid, data_out_eop
  );
  modport slave (
    input  start, frame_rows, shift_amt, acc_data, acc_valid, data_out_ready,
    output busy, done, cfg_err, acc_ready, data_out_data, data_out_valid, data_out_eop
  );
endinterface

// File: rtl/systolic_result_tx.sv
// systolic_result_tx: requantizes accumulator rows to int8, buffers them in a FIFO and streams framed output rows
// Ports: clock_sink (rising edge), reset_sink_reset (async, active high), bus (systolic_result_tx_if.slave).
// Optional: define RESULT_TX_RELU_EN to clamp negative accumulators to 0 before rounding.
module systolic_result_tx #(
  parameter int LANES = 32,
  parameter int ACC_W = 24,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input logic            clock_sink,
  input logic            reset_sink_reset,
  systolic_result_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = ACC_W + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                 state_q, state_d;
  logic [5:0]             rows_q, rows_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [4:0]             shift_q, shift_d;
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LANES*OUT_W-1:0] mem_q [DEPTH];
  logic [LANES*OUT_W-1:0] mem_d [DEPTH];
  logic                   done_q, done_d, cfg_err_q, cfg_err_d, push, pop;
  // Round half up then saturate; one extra bit keeps x + 2^(s-1) from overflowing.
  function automatic logic [OUT_W-1:0] quant(input logic [ACC_W-1:0] a, input logic [4:0] s);
    logic signed [XW-1:0] x, rnd;
    x = $signed({a[ACC_W-1], a});
`ifdef RESULT_TX_RELU_EN
    x = x[XW-1] ? '0 : x;
`endif
    rnd = (s == 5'd0) ? '0 : XW'(1) << (s - 5'd1);
    x = (x + rnd) >>> s;
    return (x > 127) ? 8'h7f : (x < -128) ? 8'h80 : x[OUT_W-1:0];
  endfunction
  assign push               = bus.acc_valid && bus.acc_ready;
  assign pop                = bus.data_out_valid && bus.data_out_ready;
  assign bus.acc_ready      = (state_q == RUN) && (cnt_q < CW'(DEPTH));
  assign bus.data_out_valid = cnt_q != '0;
  assign bus.data_out_data  = mem_q[rd_q];
  assign bus.data_out_eop   = bus.data_out_valid && (out_cnt_q == rows_q - 6'd1);
  assign bus.busy           = state_q != IDLE;
  assign bus.done           = done_q;
  assign bus.cfg_err        = cfg_err_q;
  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    shift_d   = shift_q;
    cfg_err_d = cfg_err_q;
    done_d    = 1'b0;
    in_cnt_d  = in_cnt_q + 6'(push);
    out_cnt_d = out_cnt_q + 6'(pop);
    wr_d      = wr_q + AW'(push);
    rd_d      = rd_q + AW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    mem_d     = mem_q;
    for (int k = 0; k < LANES; k++)
      mem_d[wr_q][k*OUT_W +: OUT_W] = push ? quant(bus.acc_data[k*ACC_W +: ACC_W], shift_q)
                                           : mem_q[wr_q][k*OUT_W +: OUT_W];
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.frame_rows == 6'd0 || bus.frame_rows > 6'd32 || bus.shift_amt > 5'd23)
          cfg_err_d = 1'b1;
        else begin
          rows_d    = bus.frame_rows;
          shift_d   = bus.shift_amt;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: if (push && in_cnt_q + 6'd1 == rows_q) state_d = DRAIN;
      DRAIN: if (pop && out_cnt_q == rows_q - 6'd1) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_sink or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      shift_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      mem_q     <= '{default: '0};
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      shift_q   <= shift_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      mem_q     <= mem_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end
endmodule

// File: tb/tb_systolic_result_tx.sv
// tb_systolic_result_tx: scoreboard bench for systolic_result_tx
module tb_systolic_result_tx;
  localparam int LANES = 32;
  localparam int ACC_W = 24;
  localparam int OUT_W = 8;
  localparam int IW = LANES * ACC_W;
  localparam int DW = LANES * OUT_W;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [IW-1:0] pend_acc [$];
  logic [DW:0]   pend_exp [$];
  logic [DW:0]   sb [$];
  always #5 clk = ~clk;
  systolic_result_tx_if #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus();
  systolic_result_tx #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .DEPTH(4)) dut (
    .clock_sink(clk),
    .reset_sink_reset(rst),
    .bus(bus)
  );
  function automatic logic [DW-1:0] model(input logic [IW-1:0] a, input int s);
    logic [DW-1:0] r;
    longint x;
    for (int k = 0; k < LANES; k++) begin
      x = $signed(a[k*ACC_W +: ACC_W]);
`ifdef RESULT_TX_RELU_EN
      if (x < 0) x = 0;
`endif
      if (s > 0) x = (x + (longint'(1) << (s - 1))) >>> s;
      if (x > 127) x = 127;
      if (x < -128) x = -128;
      r[k*OUT_W +: OUT_W] = 8'(x);
    end
    return r;
  endfunction
  function automatic logic [IW-1:0] rand_row();
    logic [IW-1:0] a;
    for (int k = 0; k < LANES; k++) a[k*ACC_W +: ACC_W] = 24'($urandom);
    return a;
  endfunction
  task automatic add_row(input logic [IW-1:0] a, input int s, input logic eop);
    pend_acc.push_back(a);
    pend_exp.push_back({eop, model(a, s)});
  endtask
  task automatic start_frame(input logic [5:0] rows, input logic [4:0] sh);
    bus.frame_rows = rows;
    bus.shift_amt  = sh;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask
  // One clock: offer the next pending row, move its expectation to the scoreboard on
  // acceptance, and report any output beat together with the expected beat.
  task automatic tick(output logic beat, output logic [DW:0] got, output logic [DW:0] exp, output logic dn);
    bus.acc_valid = pend_acc.size() != 0;
    bus.acc_data  = bus.acc_valid ? pend_acc[0] : '0;
    beat = bus.data_out_valid && bus.data_out_ready;
    got  = {bus.data_out_eop, bus.data_out_data};
    exp  = 'x;
    if (beat && sb.size() != 0) exp = sb.pop_front();
    if (bus.acc_valid && bus.acc_ready) begin
      void'(pend_acc.pop_front());
      sb.push_back(pend_exp.pop_front());
    end
    @(posedge clk);
    #1;
    dn = bus.done;
  endtask
  task automatic test_reset();
    bus.start = 0; bus.frame_rows = 0; bus.shift_amt = 0;
    bus.acc_data = '0; bus.acc_valid = 0; bus.data_out_ready = 1;
    #1 rst = 1'b1;
    #10;
    checks++;
    if ({bus.busy, bus.done, bus.cfg_err, bus.acc_ready, bus.data_out_valid, bus.data_out_eop} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {bus.busy, bus.done, bus.cfg_err, bus.acc_ready, bus.data_out_valid, bus.data_out_eop});
    end
    checks++;
    if (bus.data_out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.data_out_data); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_single();
    logic [IW-1:0] a;
    logic beat, dn;
    logic [DW:0] got, exp;
    logic [31:0] want;
    int nb = 0, beat_at = -1, done_at = -1;
`ifdef RESULT_TX_RELU_EN
    want = {8'h00, 8'h03, 8'h00, 8'h7f};
`else
    want = {8'h80, 8'h03, 8'hfe, 8'h7f};
`endif
    a = '0;
    a[0*ACC_W +: ACC_W] = 24'sd300;
    a[1*ACC_W +: ACC_W] = -24'sd5;
    a[2*ACC_W +: ACC_W] = 24'sd5;
    a[3*ACC_W +: ACC_W] = -24'sd300;
    add_row(a, 1, 1'b1);
    start_frame(6'd1, 5'd1);
    for (int i = 0; i < 20 && done_at < 0; i++) begin
      tick(beat, got, exp, dn);
      if (beat) begin
        checks++;
        if (got !== exp) begin failures++; $display("FAIL single_sb got=%h exp=%h", got, exp); end
        checks++;
        if (got[31:0] !== want) begin failures++; $display("FAIL single_lanes got=%h exp=%h", got[31:0], want); end
        checks++;
        if (got[DW] !== 1'b1) begin failures++; $display("FAIL single_eop got=%b exp=1", got[DW]); end
        nb++;
        beat_at = i;
      end
      if (dn) done_at = i;
    end
    checks++;
    if (nb !== 1) begin failures++; $display("FAIL single_beats got=%0d exp=1", nb); end
    checks++;
    if (done_at < 0 || done_at !== beat_at) begin failures++; $display("FAIL single_done_timing got=%0d exp=%0d", done_at, beat_at); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", bus.busy); end
  endtask
  task automatic test_frame32();
    logic [IW-1:0] a;
    logic beat, dn;
    logic [DW:0] got, exp;
    int nb = 0, nbusy = 0, first = -1, last = -1;
    bit fin = 0;
    for (int r = 0; r < 32; r++) begin
      a = rand_row();
      a[0 +: ACC_W] = 24'(r);
      add_row(a, 0, r == 31);
    end
    start_frame(6'd32, 5'd0);
    for (int i = 0; i < 100 && !fin; i++) begin
      if (bus.busy) nbusy++;
      // a start while busy (even an illegal one) must be ignored
      if (i == 5) begin bus.start = 1'b1; bus.frame_rows = 6'd0; end
      tick(beat, got, exp, dn);
      bus.start = 1'b0;
      if (beat) begin
        checks++;
        if (got !== exp) begin failures++; $display("FAIL f32_sb beat=%0d got=%h exp=%h", nb, got, exp); end
        checks++;
        if (got[7:0] !== 8'(nb)) begin failures++; $display("FAIL f32_lane0 got=%0d exp=%0d", got[7:0], nb); end
        if (first < 0) first = i;
        last = i;
        nb++;
      end
      fin = dn;
    end
    checks++;
    if (!fin) begin failures++; $display("FAIL f32_done_timeout got=0 exp=1"); end
    checks++;
    if (nb !== 32 || last - first !== 31) begin failures++; $display("FAIL f32_beats got=%0d span=%0d exp=32 span=31", nb, last - first); end
    checks++;
    if (nbusy !== 33) begin failures++; $display("FAIL f32_busy_cycles got=%0d exp=33", nbusy); end
    checks++;
    if (bus.cfg_err !== 1'b0) begin failures++; $display("FAIL f32_start_ignored cfg_err got=%b exp=0", bus.cfg_err); end
  endtask
  task automatic test_backpressure();
    logic beat, dn;
    logic [DW:0] got, exp, hold;
    int nb = 0;
    bit held = 0, fin = 0;
    for (int r = 0; r < 8; r++) add_row(rand_row(), 2, r == 7);
    bus.data_out_ready = 1'b0;
    start_frame(6'd8, 5'd2);
    for (int i = 0; i < 80 && !fin; i++) begin
      if (i == 9) begin
        checks++;
        if (bus.acc_ready !== 1'b0 || sb.size() !== 4) begin
          failures++;
          $display("FAIL bp_full acc_ready=%b stored=%0d exp acc_ready=0 stored=4", bus.acc_ready, sb.size());
        end
      end
      if (i == 10) bus.data_out_ready = 1'b1;
      if (!bus.data_out_ready && bus.data_out_valid) begin
        if (held) begin
          checks++;
          if ({bus.data_out_eop, bus.data_out_data} !== hold) begin
            failures++;
            $display("FAIL bp_hold got=%h exp=%h", {bus.data_out_eop, bus.data_out_data}, hold);
          end
        end else begin
          hold = {bus.data_out_eop, bus.data_out_data};
          held = 1;
        end
      end
      tick(beat, got, exp, dn);
      if (beat) begin
        checks++;
        if (got !== exp) begin failures++; $display("FAIL bp_sb beat=%0d got=%h exp=%h", nb, got, exp); end
        nb++;
      end
      fin = dn;
    end
    checks++;
    if (!fin || nb !== 8 || sb.size() !== 0 || pend_acc.size() !== 0) begin
      failures++;
      $display("FAIL bp_complete done=%b beats=%0d left=%0d exp done=1 beats=8 left=0", fin, nb, sb.size() + pend_acc.size());
    end
  endtask
  task automatic test_cfg_err();
    logic beat, dn;
    logic [DW:0] got, exp;
    logic [5:0] br [3] = '{6'd0, 6'd40, 6'd5};
    logic [4:0] bs [3] = '{5'd5, 5'd5, 5'd24};
    int nb = 0;
    bit fin = 0;
    checks++;
    if (bus.cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_initial got=%b exp=0", bus.cfg_err); end
    for (int j = 0; j < 3; j++) begin
      start_frame(br[j], bs[j]);
      tick(beat, got, exp, dn);
      checks++;
      if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0 || bus.acc_ready !== 1'b0) begin
        failures++;
        $display("FAIL cfg_bad%0d err=%b busy=%b acc_ready=%b exp err=1 busy=0 acc_ready=0", j, bus.cfg_err, bus.busy, bus.acc_ready);
      end
    end
    for (int r = 0; r < 3; r++) add_row(rand_row(), 4, r == 2);
    start_frame(6'd3, 5'd4);
    for (int i = 0; i < 40 && !fin; i++) begin
      tick(beat, got, exp, dn);
      if (beat) begin
        checks++;
        if (got !== exp) begin failures++; $display("FAIL cfg_legal_sb got=%h exp=%h", got, exp); end
        nb++;
      end
      fin = dn;
    end
    checks++;
    if (!fin || nb !== 3 || bus.cfg_err !== 1'b1) begin
      failures++;
      $display("FAIL cfg_legal done=%b beats=%0d err=%b exp done=1 beats=3 err=1", fin, nb, bus.cfg_err);
    end
  endtask
  task automatic test_reset_mid();
    logic beat, dn;
    logic [DW:0] got, exp;
    int nb = 0, ndone = 0;
    bit fin = 0;
    for (int r = 0; r < 8; r++) add_row(rand_row(), 3, r == 7);
    bus.data_out_ready = 1'b0;
    start_frame(6'd8, 5'd3);
    for (int i = 0; i < 3; i++) tick(beat, got, exp, dn);
    checks++;
    if (sb.size() !== 3) begin failures++; $display("FAIL rm_accepted got=%0d exp=3", sb.size()); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.cfg_err, bus.acc_ready, bus.data_out_valid, bus.data_out_eop} !== 6'b0 || bus.data_out_data !== '0) begin
      failures++;
      $display("FAIL rm_async_clear ctrl=%b data=%h exp ctrl=000000 data=0",
               {bus.busy, bus.done, bus.cfg_err, bus.acc_ready, bus.data_out_valid, bus.data_out_eop}, bus.data_out_data);
    end
    pend_acc.delete();
    pend_exp.delete();
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.data_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(beat, got, exp, dn);
      if (beat) nb++;
      if (dn) ndone++;
    end
    checks++;
    if (nb !== 0 || ndone !== 0) begin failures++; $display("FAIL rm_discard beats=%0d dones=%0d exp 0 0", nb, ndone); end
    for (int r = 0; r < 2; r++) add_row(rand_row(), 0, r == 1);
    start_frame(6'd2, 5'd0);
    for (int i = 0; i < 30 && !fin; i++) begin
      tick(beat, got, exp, dn);
      if (beat) begin
        checks++;
        if (got !== exp) begin failures++; $display("FAIL rm_sb got=%h exp=%h", got, exp); end
        checks++;
        if (got[DW] !== (nb == 1)) begin failures++; $display("FAIL rm_eop beat=%0d got=%b", nb, got[DW]); end
        nb++;
      end
      fin = dn;
    end
    checks++;
    if (!fin || nb !== 2) begin failures++; $display("FAIL rm_frame2 done=%b beats=%0d exp done=1 beats=2", fin, nb); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single();
    test_frame32();
    test_backpressure();
    test_cfg_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
